multi_engine_station: RTL

Station joining N_ENGINES engines to one ring segment: instructions arriving from upstream are dispatched round-robin to any engine able to take them, else forwarded. Engine outputs are arbitrated into a per-CC-tracked output FIFO that drives the downstream ring. It generalises the single-engine station to N engines and an explicit FIFO depth, and adds fairness between ring-forward and engine traffic and per-engine dispatch rotation.

---
 rtl/engine_station_pkg.sv | 40 ++++
 rtl/station_cc_fifo.sv | 77 +++++++
 rtl/multi_engine_station.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/engine_station_pkg.sv
// Shared types and helpers for the multi-engine ring station.
package engine_station_pkg;

  localparam int unsigned PC_WIDTH_DEF         = 8;
  localparam int unsigned CC_ID_BITS_DEF       = 2;
  localparam int unsigned FIFO_COUNT_WIDTH_DEF = 6;
  localparam int unsigned FIFO_DEPTH_DEF       = 1 << FIFO_COUNT_WIDTH_DEF;
  localparam int unsigned MAX_ENGINES          = 32;

  typedef struct packed {
    logic [CC_ID_BITS_DEF-1:0] cc_id;
    logic [PC_WIDTH_DEF-1:0]   pc;
  } item_t;

  function automatic int unsigned fifo_depth(input int unsigned count_width);
    return 1 << count_width;
  endfunction

  // One-hot grant for the first requester at or after ptr, wrapping modulo n.
  function automatic logic [MAX_ENGINES-1:0] rr_pick(
    input logic [MAX_ENGINES-1:0] req,
    input int                     ptr,
    input int                     n
  );
    logic [MAX_ENGINES-1:0] grant;
    logic                   found;
    int                     idx;
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < MAX_ENGINES; i++) begin
      idx = (ptr + i) % n;
      if (i < n && !found && req[idx[4:0]]) begin
        grant[idx[4:0]] = 1'b1;
        found           = 1'b1;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/station_cc_fifo.sv
// Circular output FIFO with a per-character-context occupancy counter.
module station_cc_fifo
  import engine_station_pkg::*;
#(
  parameter int unsigned W           = 10,
  parameter int unsigned CC_ID_BITS  = 2,
  parameter int unsigned COUNT_WIDTH = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [W-1:0]               wr_data,
  output logic                       wr_ok,
  output logic                       out_valid,
  output logic [W-1:0]               out_data,
  input  logic                       out_ready,
  output logic [COUNT_WIDTH:0]       count,
  output logic [2**CC_ID_BITS-1:0]   cc_busy,
  output logic                       is_full
);

  localparam int unsigned DEPTH = fifo_depth(COUNT_WIDTH);
  localparam int unsigned CC    = 2**CC_ID_BITS;
  localparam logic [COUNT_WIDTH:0] ONE = (COUNT_WIDTH+1)'(1);

  logic [W-1:0]             mem [DEPTH];
  logic [COUNT_WIDTH-1:0]   wr_ptr_reg;
  logic [COUNT_WIDTH-1:0]   rd_ptr_reg;
  logic [COUNT_WIDTH:0]     count_reg;
  logic                     do_rd;
  logic                     do_wr;
  logic [CC_ID_BITS-1:0]    wr_cc;
  logic [CC_ID_BITS-1:0]    rd_cc;

  assign is_full   = (count_reg == (COUNT_WIDTH+1)'(DEPTH));
  assign out_valid = (count_reg != '0);
  assign out_data  = mem[rd_ptr_reg];
  assign do_rd     = out_valid && out_ready;
  // A read in the same cycle frees the slot, so a full FIFO can still take a write.
  assign wr_ok     = !is_full || do_rd;
  assign do_wr     = wr_en && wr_ok;
  assign wr_cc     = wr_data[W-1 -: CC_ID_BITS];
  assign rd_cc     = out_data[W-1 -: CC_ID_BITS];
  assign count     = count_reg;

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_reg] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_wr) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_rd) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (do_wr && !do_rd)      count_reg <= count_reg + ONE;
      else if (do_rd && !do_wr) count_reg <= count_reg - ONE;
    end
  end

  for (genvar gi = 0; gi < CC; gi++) begin : g_cc
    logic [COUNT_WIDTH:0] cnt_reg;
    logic                 inc;
    logic                 dec;
    assign inc = do_wr && (wr_cc == CC_ID_BITS'(gi));
    assign dec = do_rd && (rd_cc == CC_ID_BITS'(gi));
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)              cnt_reg <= '0;
      else if (inc && !dec)  cnt_reg <= cnt_reg + ONE;
      else if (dec && !inc)  cnt_reg <= cnt_reg - ONE;
    end
    assign cc_busy[gi] = (cnt_reg != '0);
  end

endmodule

// File: rtl/multi_engine_station.sv
// Ring station: round-robin dispatch of ring items to N engines, fair merge of
// forwarded ring items and engine results into the downstream output FIFO.
module multi_engine_station
  import engine_station_pkg::*;
#(
  parameter  int unsigned N_ENGINES        = 2,
  parameter  int unsigned PC_WIDTH         = 8,
  parameter  int unsigned CC_ID_BITS       = 2,
  parameter  int unsigned FIFO_COUNT_WIDTH = 6,
  localparam int unsigned W                = PC_WIDTH + CC_ID_BITS,
  localparam int unsigned CC               = 2**CC_ID_BITS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ring_in_valid,
  input  logic [W-1:0]              ring_in_data,
  output logic                      ring_in_ready,
  output logic                      ring_out_valid,
  output logic [W-1:0]              ring_out_data,
  input  logic                      ring_out_ready,
  input  logic [N_ENGINES-1:0]      eng_req_valid,
  input  logic [N_ENGINES*W-1:0]    eng_req_data,
  output logic [N_ENGINES-1:0]      eng_req_ready,
  output logic [N_ENGINES-1:0]      eng_disp_valid,
  output logic [N_ENGINES*W-1:0]    eng_disp_data,
  input  logic [N_ENGINES-1:0]      eng_disp_ready,
  input  logic [N_ENGINES-1:0]      eng_running,
  input  logic [N_ENGINES-1:0]      eng_full,
  input  logic [N_ENGINES*CC-1:0]   eng_elab,
  output logic [CC-1:0]             elaborating_chars,
  output logic                      running,
  output logic                      full,
  output logic [FIFO_COUNT_WIDTH:0] fifo_count
);

  localparam int unsigned PW = (N_ENGINES > 1) ? $clog2(N_ENGINES) : 1;

  logic [PW-1:0]          dptr_reg;
  logic [PW-1:0]          eptr_reg;
  logic                   tok_reg;
  logic [MAX_ENGINES-1:0] disp_pick;
  logic [MAX_ENGINES-1:0] eng_pick;
  logic [N_ENGINES-1:0]   disp_sel;
  logic [N_ENGINES-1:0]   eng_sel;
  logic [PW-1:0]          disp_idx;
  logic [PW-1:0]          eng_idx;
  logic [W-1:0]           eng_data;
  logic                   any_disp;
  logic                   disp_fire;
  logic                   ring_fwd;
  logic                   any_eng;
  logic                   ring_win;
  logic                   eng_win;
  logic                   ring_grant;
  logic                   eng_grant;
  logic                   wr_ok;
  logic                   wr_en;
  logic [W-1:0]           wr_data;
  logic [CC-1:0]          cc_busy;
  logic [CC-1:0]          elab_any;
  logic                   fifo_full;

  assign disp_pick = rr_pick(MAX_ENGINES'(eng_disp_ready), int'(dptr_reg), int'(N_ENGINES));
  assign eng_pick  = rr_pick(MAX_ENGINES'(eng_req_valid), int'(eptr_reg), int'(N_ENGINES));
  assign disp_sel  = disp_pick[N_ENGINES-1:0];
  assign eng_sel   = eng_pick[N_ENGINES-1:0];

  if (N_ENGINES < MAX_ENGINES) begin : g_pad
    logic unused_pick_bits;
    assign unused_pick_bits = ^{disp_pick[MAX_ENGINES-1:N_ENGINES],
                                eng_pick[MAX_ENGINES-1:N_ENGINES]};
  end

  always_comb begin
    disp_idx = '0;
    eng_idx  = '0;
    eng_data = '0;
    for (int i = 0; i < N_ENGINES; i++) begin
      if (disp_sel[i]) disp_idx = PW'(i);
      if (eng_sel[i]) begin
        eng_idx  = PW'(i);
        eng_data = eng_req_data[i*W +: W];
      end
    end
  end

  assign any_disp  = rst && (|eng_disp_ready);
  assign disp_fire = rst && ring_in_valid && any_disp;
  assign ring_fwd  = rst && ring_in_valid && !any_disp;
  assign any_eng   = rst && (|eng_req_valid);

  // tok=0 favours the ring-forward item, tok=1 favours engine output.
  assign ring_win   = !any_eng || !tok_reg;
  assign eng_win    = !ring_fwd || tok_reg;
  assign ring_grant = ring_fwd && ring_win && wr_ok;
  assign eng_grant  = any_eng && eng_win && wr_ok;
  assign wr_en      = ring_grant || eng_grant;
  assign wr_data    = ring_grant ? ring_in_data : eng_data;

  assign ring_in_ready  = rst && (any_disp || (wr_ok && ring_win));
  assign eng_req_ready  = eng_grant ? eng_sel : '0;
  assign eng_disp_valid = (rst && ring_in_valid) ? disp_sel : '0;
  assign eng_disp_data  = {N_ENGINES{ring_in_data}};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dptr_reg <= '0;
      eptr_reg <= '0;
      tok_reg  <= 1'b0;
    end else begin
      if (disp_fire)
        dptr_reg <= (disp_idx == PW'(N_ENGINES-1)) ? '0 : disp_idx + 1'b1;
      if (eng_grant)
        eptr_reg <= (eng_idx == PW'(N_ENGINES-1)) ? '0 : eng_idx + 1'b1;
      if (ring_fwd && any_eng && wr_ok)
        tok_reg <= !tok_reg;
    end
  end

  station_cc_fifo #(
    .W           (W),
    .CC_ID_BITS  (CC_ID_BITS),
    .COUNT_WIDTH (FIFO_COUNT_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .wr_ok     (wr_ok),
    .out_valid (ring_out_valid),
    .out_data  (ring_out_data),
    .out_ready (ring_out_ready),
    .count     (fifo_count),
    .cc_busy   (cc_busy),
    .is_full   (fifo_full)
  );

  always_comb begin
    elab_any = cc_busy;
    for (int e = 0; e < N_ENGINES; e++) elab_any = elab_any | eng_elab[e*CC +: CC];
  end

  assign elaborating_chars = rst ? elab_any : '0;
  assign running = rst && ((fifo_count != '0) || ring_in_valid || (|eng_running));
  assign full    = rst && fifo_full && (&eng_full);

endmodule
